// File: rtl/uart_rx_pkg.sv
// Shared definitions for the receive UART: register offsets, STATUS layout
// and the receiver state encoding.
package uart_rx_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int STAT_OVERRUN_BIT = 16;
  localparam int STAT_FRAMING_BIT = 17;
  localparam int COUNT_W          = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  function automatic logic [31:0] status_word(input logic [COUNT_W-1:0] count,
                                              input logic overrun,
                                              input logic framing);
    logic [31:0] w;
    w                   = '0;
    w[COUNT_W-1:0]      = count;
    w[STAT_OVERRUN_BIT] = overrun;
    w[STAT_FRAMING_BIT] = framing;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; stale entries are unreachable while count says empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// Wishbone dbus receive UART: 16x oversampled 8N1 deserialiser feeding a byte
// FIFO, with DATA/STATUS/CTRL registers and a level interrupt.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int                AWIDTH = 8,
  parameter logic [AWIDTH-1:0] ADDR   = 8'h60,
  parameter int                DEPTH  = 16
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] wb_dbus_adr,
  input  logic [31:0] wb_dbus_dat,
  input  logic [3:0]  wb_dbus_sel,
  input  logic        wb_dbus_we,
  input  logic        wb_dbus_cyc,
  output logic [31:0] rdt,
  output logic        ack,
  input  logic        sample_en,
  input  logic        rx,
  output logic        irq
);

  localparam int CW = $clog2(DEPTH + 1);

  logic            rx_meta, rxs;
  rx_state_t       state;
  logic [3:0]      tc;
  logic [2:0]      bi;
  logic [7:0]      shreg;
  logic            stop_tick, push_req, frame_err;
  logic [7:0]      fifo_dout;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  logic            start;
  logic [1:0]      reg_sel;
  logic [31:0]     rd_word;
  logic            pop_q, wr_ctrl_q, ctrl_d_q, clr_ovr_q, clr_frm_q;
  logic            overrun, framing, ctrl, overrun_set;
  logic            unused_bits;

  assign unused_bits = ^{wb_dbus_sel, wb_dbus_adr, wb_dbus_dat};

  // NOTE: non-blocking assignments make rx_meta and rxs two distinct flops.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign stop_tick = sample_en && (state == ST_STOP) && (tc == 4'd15);
  assign push_req  = stop_tick && rxs;
  assign frame_err = stop_tick && !rxs;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state <= ST_IDLE;
      tc    <= '0;
      bi    <= '0;
      shreg <= '0;
    end else if (sample_en) begin
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state <= ST_START;
            tc    <= '0;
          end
        end
        ST_START: begin
          // Re-check mid start bit so short low glitches are ignored.
          if (tc == 4'd7) begin
            if (!rxs) begin
              state <= ST_DATA;
              tc    <= '0;
              bi    <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            tc <= tc + 4'd1;
          end
        end
        ST_DATA: begin
          tc <= tc + 4'd1;
          if (tc == 4'd15) begin
            shreg <= {rxs, shreg[7:1]};
            if (bi == 3'd7) state <= ST_STOP;
            else            bi    <= bi + 3'd1;
          end
        end
        ST_STOP: begin
          tc <= tc + 4'd1;
          if (tc == 4'd15) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (wb_clk),
    .rst   (wb_rst),
    .push  (push_req),
    .pop   (pop_q),
    .din   (shreg),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign start   = wb_dbus_cyc && (wb_dbus_adr[31 -: AWIDTH] == ADDR) && !ack;
  assign reg_sel = wb_dbus_adr[3:2];

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      REG_DATA:   if (!fifo_empty) rd_word = {23'd0, 1'b1, fifo_dout};
      REG_STATUS: rd_word = status_word(COUNT_W'(fifo_count), overrun, framing);
      REG_CTRL:   rd_word = {31'd0, ctrl};
      default:    rd_word = '0;
    endcase
  end

  // Decoded strobes are registered at access start so they fire in the ack cycle.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      ack       <= 1'b0;
      rdt       <= '0;
      pop_q     <= 1'b0;
      wr_ctrl_q <= 1'b0;
      ctrl_d_q  <= 1'b0;
      clr_ovr_q <= 1'b0;
      clr_frm_q <= 1'b0;
    end else begin
      ack       <= start;
      rdt       <= (start && !wb_dbus_we) ? rd_word : '0;
      pop_q     <= start && !wb_dbus_we && (reg_sel == REG_DATA) && !fifo_empty;
      wr_ctrl_q <= start && wb_dbus_we && (reg_sel == REG_CTRL);
      ctrl_d_q  <= wb_dbus_dat[0];
      clr_ovr_q <= start && wb_dbus_we && (reg_sel == REG_STATUS) && wb_dbus_dat[STAT_OVERRUN_BIT];
      clr_frm_q <= start && wb_dbus_we && (reg_sel == REG_STATUS) && wb_dbus_dat[STAT_FRAMING_BIT];
    end
  end

  assign overrun_set = push_req && fifo_full && !pop_q;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      overrun <= 1'b0;
      framing <= 1'b0;
      ctrl    <= 1'b0;
      irq     <= 1'b0;
    end else begin
      overrun <= overrun_set || (overrun && !clr_ovr_q);
      framing <= frame_err || (framing && !clr_frm_q);
      if (wr_ctrl_q) ctrl <= ctrl_d_q;
      irq <= ctrl && (fifo_count != '0);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames at 16 strobes per bit, bus
// reads/writes, and a queue-based model of the FIFO and flags.
module tb_uart_rx;

  localparam logic [7:0] DEV   = 8'h60;
  localparam int         DEPTH = 16;
  localparam logic [1:0] R_DATA = 2'd0, R_STATUS = 2'd1, R_CTRL = 2'd2, R_RSVD = 2'd3;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic [31:0] wb_dbus_adr = '0;
  logic [31:0] wb_dbus_dat = '0;
  logic [3:0]  wb_dbus_sel = 4'hf;
  logic        wb_dbus_we  = 1'b0;
  logic        wb_dbus_cyc = 1'b0;
  logic [31:0] rdt;
  logic        ack;
  logic        sample_en = 1'b0;
  logic        rx = 1'b1;
  logic        irq;

  int total = 0;
  int bad   = 0;

  byte unsigned mq[$];
  bit           m_ovr = 0, m_frm = 0, m_ctrl = 0;

  uart_rx #(.AWIDTH(8), .ADDR(DEV), .DEPTH(DEPTH)) dut (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .wb_dbus_adr (wb_dbus_adr),
    .wb_dbus_dat (wb_dbus_dat),
    .wb_dbus_sel (wb_dbus_sel),
    .wb_dbus_we  (wb_dbus_we),
    .wb_dbus_cyc (wb_dbus_cyc),
    .rdt         (rdt),
    .ack         (ack),
    .sample_en   (sample_en),
    .rx          (rx),
    .irq         (irq)
  );

  always #5 wb_clk = ~wb_clk;

  // 16x strobe: one clock in four
  initial begin
    forever begin
      repeat (3) begin
        @(negedge wb_clk);
        sample_en = 1'b0;
      end
      @(negedge wb_clk);
      sample_en = 1'b1;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic void model_rx(input byte unsigned b, input bit stop);
    if (!stop)                    m_frm = 1;
    else if (mq.size() >= DEPTH)  m_ovr = 1;
    else                          mq.push_back(b);
  endfunction

  function automatic logic [31:0] model_status();
    return {14'd0, m_frm, m_ovr, 7'd0, 9'(mq.size())};
  endfunction

  function automatic logic [31:0] model_data_read();
    if (mq.size() == 0) return 32'd0;
    return {23'd0, 1'b1, mq.pop_front()};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic wait_strobes(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge wb_clk); while (!sample_en);
    end
  endtask

  task automatic send_frame(input byte unsigned b, input bit stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    wait_strobes(1);
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk);
      rx = bits[i];
      wait_strobes(16);
    end
    @(negedge wb_clk);
    rx = 1'b1;
    wait_strobes(16);
  endtask

  task automatic bus_access(input logic [1:0] r, input logic we, input logic [31:0] wdat,
                            output logic [31:0] d);
    bit got;
    @(negedge wb_clk);
    wb_dbus_adr = {DEV, 20'h0, r, 2'b00};
    wb_dbus_we  = we;
    wb_dbus_dat = wdat;
    wb_dbus_cyc = 1'b1;
    got = 0;
    d   = '0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge wb_clk);
      if (ack) begin
        got = 1;
        d   = rdt;
      end
    end
    wb_dbus_cyc = 1'b0;
    wb_dbus_we  = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL bus_ack reg=%0d: ack=0 required=1 within 4 cycles", r);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(posedge wb_clk);
    @(negedge wb_clk);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    total++; if (ack !== 1'b0)    begin bad++; $display("FAIL reset_ack: got=%b exp=0", ack); end
    total++; if (rdt !== 32'd0)   begin bad++; $display("FAIL reset_rdt: got=%h exp=0", rdt); end
    total++; if (irq !== 1'b0)    begin bad++; $display("FAIL reset_irq: got=%b exp=0", irq); end
    bus_access(R_STATUS, 0, 0, d);
    total++; if (d !== 32'd0)     begin bad++; $display("FAIL reset_status: got=%h exp=0", d); end
    bus_access(R_CTRL, 0, 0, d);
    total++; if (d !== 32'd0)     begin bad++; $display("FAIL reset_ctrl: got=%h exp=0", d); end
    bus_access(R_DATA, 0, 0, d);
    total++; if (d !== 32'd0)     begin bad++; $display("FAIL reset_data: got=%h exp=0", d); end
  endtask

  task automatic test_single_byte();
    logic [31:0] d;
    send_frame(8'hA5, 1);
    model_rx(8'hA5, 1);
    bus_access(R_STATUS, 0, 0, d);
    total++; if (d !== 32'h001)   begin bad++; $display("FAIL single_status: got=%h exp=001", d); end
    bus_access(R_DATA, 0, 0, d);
    void'(model_data_read());
    total++; if (d !== 32'h1A5)   begin bad++; $display("FAIL single_data: got=%h exp=1a5", d); end
    bus_access(R_STATUS, 0, 0, d);
    total++; if (d !== 32'h000)   begin bad++; $display("FAIL single_status_after: got=%h exp=0", d); end
  endtask

  task automatic test_glitch();
    logic [31:0] d, e;
    byte unsigned b;
    wait_strobes(1);
    @(negedge wb_clk);
    rx = 1'b0;
    wait_strobes(4);
    @(negedge wb_clk);
    rx = 1'b1;
    wait_strobes(40);
    bus_access(R_STATUS, 0, 0, d);
    total++; if (d !== 32'd0)     begin bad++; $display("FAIL glitch_status: got=%h exp=0", d); end
    b = 8'($urandom);
    send_frame(b, 1);
    model_rx(b, 1);
    bus_access(R_DATA, 0, 0, d);
    e = model_data_read();
    total++; if (d !== e)         begin bad++; $display("FAIL glitch_next_byte: got=%h exp=%h", d, e); end
  endtask

  task automatic test_framing();
    logic [31:0] d;
    send_frame(8'h3C, 0);
    model_rx(8'h3C, 0);
    bus_access(R_STATUS, 0, 0, d);
    total++; if (d !== 32'h20000) begin bad++; $display("FAIL framing_status: got=%h exp=20000", d); end
    bus_access(R_STATUS, 1, 32'h20000, d);
    m_frm = 0;
    bus_access(R_STATUS, 0, 0, d);
    total++; if (d !== 32'd0)     begin bad++; $display("FAIL framing_clear: got=%h exp=0", d); end
  endtask

  task automatic test_random_bytes();
    logic [31:0] d, e;
    byte unsigned b;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send_frame(b, 1);
      model_rx(b, 1);
      if ($urandom_range(0, 1) == 1) begin
        bus_access(R_DATA, 0, 0, d);
        e = model_data_read();
        total++; if (d !== e) begin bad++; $display("FAIL random_data[%0d]: got=%h exp=%h", i, d, e); end
      end
    end
    bus_access(R_STATUS, 0, 0, d);
    e = model_status();
    total++; if (d !== e)         begin bad++; $display("FAIL random_status: got=%h exp=%h", d, e); end
    while (mq.size() > 0) begin
      bus_access(R_DATA, 0, 0, d);
      e = model_data_read();
      total++; if (d !== e)       begin bad++; $display("FAIL random_drain: got=%h exp=%h", d, e); end
    end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    for (int i = 0; i <= 16; i++) begin
      send_frame(8'(i), 1);
      model_rx(8'(i), 1);
    end
    bus_access(R_STATUS, 0, 0, d);
    total++; if (d !== 32'h10010) begin bad++; $display("FAIL overrun_status: got=%h exp=10010", d); end
    for (int i = 0; i <= 16; i++) begin
      bus_access(R_DATA, 0, 0, d);
      void'(model_data_read());
      if (i < 16) begin
        total++; if (d !== 32'h100 + 32'(i)) begin bad++; $display("FAIL overrun_data[%0d]: got=%h exp=%h", i, d, 32'h100 + 32'(i)); end
      end else begin
        total++; if (d !== 32'd0) begin bad++; $display("FAIL overrun_empty_read: got=%h exp=0", d); end
      end
    end
    bus_access(R_STATUS, 1, 32'h10000, d);
    m_ovr = 0;
    bus_access(R_STATUS, 0, 0, d);
    total++; if (d !== 32'd0)     begin bad++; $display("FAIL overrun_clear: got=%h exp=0", d); end
  endtask

  task automatic test_push_pop();
    logic [31:0] d, e;
    byte unsigned b, nb;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1);
      model_rx(b, 1);
    end
    nb = 8'($urandom);
    e  = {23'd0, 1'b1, mq[0]};
    // Frame push lands on strobe 153 after the common start strobe; the read
    // is timed so its ack cycle is that same strobe cycle.
    fork
      send_frame(nb, 1);
      begin
        wait_strobes(1);
        wait_strobes(152);
        repeat (2) @(negedge wb_clk);
        bus_access(R_DATA, 0, 0, d);
      end
    join
    void'(model_data_read());
    model_rx(nb, 1);
    total++; if (d !== e)         begin bad++; $display("FAIL pushpop_head: got=%h exp=%h", d, e); end
    bus_access(R_STATUS, 0, 0, d);
    total++; if (d !== 32'h010)   begin bad++; $display("FAIL pushpop_status: got=%h exp=010", d); end
    for (int i = 0; i < DEPTH; i++) begin
      bus_access(R_DATA, 0, 0, d);
      e = model_data_read();
      total++; if (d !== e)       begin bad++; $display("FAIL pushpop_drain[%0d]: got=%h exp=%h", i, d, e); end
    end
  endtask

  task automatic test_irq();
    logic [31:0] d, e;
    byte unsigned b;
    bus_access(R_CTRL, 1, 32'h1, d);
    m_ctrl = 1;
    bus_access(R_CTRL, 0, 0, d);
    total++; if (d !== 32'h1)     begin bad++; $display("FAIL irq_ctrl_read: got=%h exp=1", d); end
    total++; if (irq !== 1'b0)    begin bad++; $display("FAIL irq_idle: got=%b exp=0", irq); end
    b = 8'($urandom);
    send_frame(b, 1);
    model_rx(b, 1);
    total++; if (irq !== 1'b1)    begin bad++; $display("FAIL irq_rise: got=%b exp=1", irq); end
    bus_access(R_DATA, 0, 0, d);
    e = model_data_read();
    total++; if (d !== e)         begin bad++; $display("FAIL irq_data: got=%h exp=%h", d, e); end
    @(negedge wb_clk);
    total++; if (irq !== 1'b1)    begin bad++; $display("FAIL irq_ack_plus1: got=%b exp=1", irq); end
    @(negedge wb_clk);
    total++; if (irq !== 1'b0)    begin bad++; $display("FAIL irq_ack_plus2: got=%b exp=0", irq); end
  endtask

  task automatic test_bad_addr();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      @(negedge wb_clk);
      if (i > 0) begin
        total++; if (ack !== 1'b0 || rdt !== 32'd0) begin
          bad++; $display("FAIL badaddr[%0d]: ack=%b rdt=%h exp ack=0 rdt=0", i, ack, rdt);
        end
      end
      wb_dbus_adr = {DEV ^ (8'd1 << $urandom_range(0, 7)), 20'($urandom), R_CTRL, 2'b00};
      wb_dbus_we  = 1'($urandom);
      wb_dbus_dat = '0;
      wb_dbus_cyc = 1'b1;
    end
    @(negedge wb_clk);
    wb_dbus_cyc = 1'b0;
    wb_dbus_we  = 1'b0;
    total++; if (ack !== 1'b0 || rdt !== 32'd0) begin bad++; $display("FAIL badaddr_last: ack=%b rdt=%h exp ack=0 rdt=0", ack, rdt); end
    bus_access(R_CTRL, 0, 0, d);
    total++; if (d !== {31'd0, m_ctrl}) begin bad++; $display("FAIL badaddr_ctrl_kept: got=%h exp=%h", d, {31'd0, m_ctrl}); end
    bus_access(R_RSVD, 1, 32'hFFFF_FFFF, d);
    bus_access(R_RSVD, 0, 0, d);
    total++; if (d !== 32'd0)     begin bad++; $display("FAIL rsvd_read: got=%h exp=0", d); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    byte unsigned b;
    b = 8'($urandom);
    send_frame(b, 1);
    model_rx(b, 1);
    wait_strobes(1);
    @(negedge wb_clk);
    rx = 1'b0;
    wait_strobes(40);
    @(negedge wb_clk);
    wb_rst = 1'b1;
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b0;
    rx     = 1'b1;
    mq.delete();
    m_ovr  = 0;
    m_frm  = 0;
    m_ctrl = 0;
    wait_strobes(200);
    total++; if (irq !== 1'b0)    begin bad++; $display("FAIL midreset_irq: got=%b exp=0", irq); end
    bus_access(R_STATUS, 0, 0, d);
    total++; if (d !== model_status()) begin bad++; $display("FAIL midreset_status: got=%h exp=%h", d, model_status()); end
    bus_access(R_CTRL, 0, 0, d);
    total++; if (d !== 32'd0)     begin bad++; $display("FAIL midreset_ctrl: got=%h exp=0", d); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_framing();
    test_random_bytes();
    test_overrun();
    test_push_pop();
    test_irq();
    test_bad_addr();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
